// File: rtl/frame_writer.sv
// Frame writer: converts RGB565 capture pixels to RGB444 frame-buffer writes, one write per accepted pixel (latency 1).
// Optional macro FRAME_WRITER_DECIMATE_EN keeps only even-x/even-y pixels; no backpressure, excess pixels are dropped and flagged.
module frame_writer #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              p_clock,
  input  logic              reset,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  input  logic              capture_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic [7:0]        frame_count,
  output logic              overflow,
  output logic              short_frame
);

  localparam int CW = ADDR_W + 1;
`ifdef FRAME_WRITER_DECIMATE_EN
  localparam int BUF_SIZE = (H_PIXELS / 2) * (V_LINES / 2);
`else
  localparam int BUF_SIZE = H_PIXELS * V_LINES;
`endif
  localparam logic [CW-1:0] BUF_CNT = CW'(BUF_SIZE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] wcnt;

  logic          keep;
  logic          full;
  logic          write;
  logic [CW-1:0] wcnt_next;

  // RGB565 -> RGB444 drops the low bit(s) of each channel; these inputs are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{pixel_data[11], pixel_data[6:5], pixel_data[0]};

  always_comb begin
`ifdef FRAME_WRITER_DECIMATE_EN
    keep = ~x[0] & ~y[0];
`else
    keep = 1'b1;
`endif
    full      = (wcnt == BUF_CNT);
    write     = (state == CAPTURE) && pixel_valid && keep && !full;
    wcnt_next = write ? wcnt + CNT_ONE : wcnt;
  end

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      x           <= '0;
      y           <= '0;
      wcnt        <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_req) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end
        SYNC: begin
          if (!capture_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (frame_done) begin
            state       <= CAPTURE;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            x           <= '0;
            y           <= '0;
            wcnt        <= '0;
            wr_addr     <= '0;
          end
        end
        CAPTURE: begin
          if (pixel_valid) begin
            if (write) begin
              wr_en   <= 1'b1;
              wr_addr <= wcnt[ADDR_W-1:0];
              wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
            end else if (keep && full) begin
              overflow <= 1'b1;
            end
            if (x == X_LAST) begin
              x <= '0;
              y <= y + Y_ONE;
            end else begin
              x <= x + X_ONE;
            end
          end
          wcnt <= wcnt_next;
          // A pixel coinciding with frame_done lands in the ending frame before the clear below.
          if (frame_done) begin
            frame_count <= frame_count + 8'd1;
            if (wcnt_next < BUF_CNT) short_frame <= 1'b1;
            x    <= '0;
            y    <= '0;
            wcnt <= '0;
            if (!write) wr_addr <= '0;
            if (!capture_req) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a 4x4 frame; writes are logged on the falling edge and checked per scenario.
module tb_frame_writer;

  localparam int H = 4;
  localparam int V = 4;
  localparam int AW = 4;

  logic          p_clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   pixel_data = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_done = 1'b0;
  logic          capture_req = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic [7:0]    frame_count;
  logic          overflow;
  logic          short_frame;

  int n_checks = 0;
  int n_pass = 0;

  logic [AW-1:0] log_addr[$];
  logic [11:0]   log_data[$];

  logic [15:0] pix_tbl[4];
  logic [11:0] exp_tbl[4];

  frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .p_clock(p_clock), .reset(reset), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .capture_req(capture_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_count(frame_count), .overflow(overflow),
    .short_frame(short_frame)
  );

  always #5 p_clock = ~p_clock;

  always @(negedge p_clock) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic pv, input logic [15:0] pd, input logic fd);
    @(negedge p_clock);
    pixel_valid = pv;
    pixel_data  = pd;
    frame_done  = fd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 4'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 12'h000) $display("FAIL reset_wr_data: got %h want 000", wr_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b0) $display("FAIL reset_short_frame: got %0b want 0", short_frame); else n_pass++;
    @(negedge p_clock);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_sync_discard();
    capture_req = 1'b1;
    idle(1);
    n_checks++; if (busy !== 1'b1) $display("FAIL sync_busy: got %0b want 1", busy); else n_pass++;
    clear_log();
    repeat (3) drive(1'b1, 16'hF81F, 1'b0);
    idle(2);
    n_checks++; if (log_addr.size() != 0) $display("FAIL sync_no_write: got %0d writes want 0", log_addr.size()); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL sync_busy_hold: got %0b want 1", busy); else n_pass++;
  endtask

  task automatic test_full_frame();
    clear_log();
    drive(1'b0, 16'h0000, 1'b1);
    repeat (16) drive(1'b1, 16'hF81F, 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    idle(2);
    n_checks++; if (log_addr.size() != 16) $display("FAIL full_count: got %0d writes want 16", log_addr.size()); else n_pass++;
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      n_checks++; if (log_addr[i] !== 4'(i)) $display("FAIL full_addr[%0d]: got %0d want %0d", i, log_addr[i], i); else n_pass++;
      n_checks++; if (log_data[i] !== 12'hF0F) $display("FAIL full_data[%0d]: got %h want F0F", i, log_data[i]); else n_pass++;
    end
    n_checks++; if (frame_count !== 8'd1) $display("FAIL full_frame_count: got %0d want 1", frame_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL full_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b0) $display("FAIL full_short: got %0b want 0", short_frame); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy: got %0b want 1", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    clear_log();
    repeat (17) drive(1'b1, 16'h1234, 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    idle(2);
    n_checks++; if (log_addr.size() != 16) $display("FAIL ovf_count: got %0d writes want 16", log_addr.size()); else n_pass++;
    if (log_addr.size() == 16) begin
      n_checks++; if (log_addr[15] !== 4'd15) $display("FAIL ovf_last_addr: got %0d want 15", log_addr[15]); else n_pass++;
      n_checks++; if (log_data[0] !== 12'h14A) $display("FAIL ovf_data: got %h want 14A", log_data[0]); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b0) $display("FAIL ovf_short: got %0b want 0", short_frame); else n_pass++;
    n_checks++; if (frame_count !== 8'd2) $display("FAIL ovf_frame_count: got %0d want 2", frame_count); else n_pass++;
  endtask

  task automatic test_short_frame();
    clear_log();
    for (int i = 0; i < 10; i++) drive(1'b1, pix_tbl[i % 4], 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    idle(2);
    n_checks++; if (log_addr.size() != 10) $display("FAIL short_count: got %0d writes want 10", log_addr.size()); else n_pass++;
    for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
      n_checks++; if (log_addr[i] !== 4'(i)) $display("FAIL short_addr[%0d]: got %0d want %0d", i, log_addr[i], i); else n_pass++;
      n_checks++; if (log_data[i] !== exp_tbl[i % 4]) $display("FAIL short_data[%0d]: got %h want %h", i, log_data[i], exp_tbl[i % 4]); else n_pass++;
    end
    n_checks++; if (short_frame !== 1'b1) $display("FAIL short_flag: got %0b want 1", short_frame); else n_pass++;
    n_checks++; if (frame_count !== 8'd3) $display("FAIL short_frame_count: got %0d want 3", frame_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL short_ovf_sticky: got %0b want 1", overflow); else n_pass++;
  endtask

  task automatic test_coincident();
    clear_log();
    repeat (15) drive(1'b1, 16'hF81F, 1'b0);
    drive(1'b1, 16'h07E0, 1'b1);
    drive(1'b1, 16'h1234, 1'b0);
    idle(2);
    n_checks++; if (log_addr.size() != 17) $display("FAIL coin_count: got %0d writes want 17", log_addr.size()); else n_pass++;
    if (log_addr.size() == 17) begin
      n_checks++; if (log_addr[15] !== 4'd15) $display("FAIL coin_end_addr: got %0d want 15", log_addr[15]); else n_pass++;
      n_checks++; if (log_data[15] !== 12'h0F0) $display("FAIL coin_end_data: got %h want 0F0", log_data[15]); else n_pass++;
      n_checks++; if (log_addr[16] !== 4'd0) $display("FAIL coin_next_addr: got %0d want 0", log_addr[16]); else n_pass++;
      n_checks++; if (log_data[16] !== 12'h14A) $display("FAIL coin_next_data: got %h want 14A", log_data[16]); else n_pass++;
    end
    n_checks++; if (frame_count !== 8'd4) $display("FAIL coin_frame_count: got %0d want 4", frame_count); else n_pass++;
  endtask

  task automatic test_flag_clear();
    capture_req = 1'b0;
    drive(1'b0, 16'h0000, 1'b1);
    idle(2);
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (frame_count !== 8'd5) $display("FAIL stop_frame_count: got %0d want 5", frame_count); else n_pass++;
    capture_req = 1'b1;
    idle(2);
    n_checks++; if (overflow !== 1'b1) $display("FAIL sync_ovf_held: got %0b want 1", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b1) $display("FAIL sync_short_held: got %0b want 1", short_frame); else n_pass++;
    drive(1'b0, 16'h0000, 1'b1);
    idle(1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b0) $display("FAIL clr_short: got %0b want 0", short_frame); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL clr_busy: got %0b want 1", busy); else n_pass++;
  endtask

  task automatic test_reset_midframe(input int exp_restart);
    repeat (3) drive(1'b1, 16'hFFFF, 1'b0);
    drive(1'b1, 16'hF81F, 1'b0);
    @(posedge p_clock);
    #1;
    n_checks++; if (wr_en !== 1'b1) $display("FAIL mid_wr_en_before: got %0b want 1", wr_en); else n_pass++;
    reset = 1'b1;
    pixel_valid = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 4'd0) $display("FAIL mid_wr_addr: got %0d want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 12'h000) $display("FAIL mid_wr_data: got %h want 000", wr_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (frame_count !== 8'd0) $display("FAIL mid_frame_count: got %0d want 0", frame_count); else n_pass++;
    @(negedge p_clock);
    reset = 1'b0;
    clear_log();
    repeat (3) drive(1'b1, 16'hF81F, 1'b0);
    idle(2);
    n_checks++; if (log_addr.size() != 0) $display("FAIL restart_sync_writes: got %0d want 0", log_addr.size()); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy: got %0b want 1", busy); else n_pass++;
    drive(1'b0, 16'h0000, 1'b1);
    repeat (2) drive(1'b1, 16'h1234, 1'b0);
    idle(2);
    n_checks++; if (log_addr.size() != exp_restart) $display("FAIL restart_count: got %0d want %0d", log_addr.size(), exp_restart); else n_pass++;
    if (log_addr.size() > 0) begin
      n_checks++; if (log_addr[0] !== 4'd0) $display("FAIL restart_addr: got %0d want 0", log_addr[0]); else n_pass++;
    end
  endtask

`ifdef FRAME_WRITER_DECIMATE_EN
  task automatic test_decimate();
    clear_log();
    drive(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, pix_tbl[i % 4], 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    idle(2);
    // Kept pixels are indices 0, 2, 8, 10 of the raster, i.e. table entries 0, 2, 0, 2.
    n_checks++; if (log_addr.size() != 4) $display("FAIL dec_count: got %0d writes want 4", log_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      n_checks++; if (log_addr[i] !== 4'(i)) $display("FAIL dec_addr[%0d]: got %0d want %0d", i, log_addr[i], i); else n_pass++;
      n_checks++; if (log_data[i] !== exp_tbl[(i % 2) * 2]) $display("FAIL dec_data[%0d]: got %h want %h", i, log_data[i], exp_tbl[(i % 2) * 2]); else n_pass++;
    end
    n_checks++; if (frame_count !== 8'd1) $display("FAIL dec_frame_count: got %0d want 1", frame_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL dec_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (short_frame !== 1'b0) $display("FAIL dec_short: got %0b want 0", short_frame); else n_pass++;
  endtask
`endif

  initial begin
    pix_tbl[0] = 16'hF81F; exp_tbl[0] = 12'hF0F;
    pix_tbl[1] = 16'h1234; exp_tbl[1] = 12'h14A;
    pix_tbl[2] = 16'h07E0; exp_tbl[2] = 12'h0F0;
    pix_tbl[3] = 16'hFFFF; exp_tbl[3] = 12'hFFF;
    test_reset();
    test_sync_discard();
`ifdef FRAME_WRITER_DECIMATE_EN
    test_decimate();
    test_reset_midframe(1);
`else
    test_full_frame();
    test_overflow();
    test_short_frame();
    test_coincident();
    test_flag_clear();
    test_reset_midframe(2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
